// File: rtl/prefetch_stride_gen.sv
// Stride prefetcher for L1 demand misses.
// Keeps one stride tracker per miss type (instruction / data). When a type's
// miss stream repeats the same nonzero line stride often enough, the next
// line in the stream becomes a prefetch candidate. Candidates wait in a
// small FIFO and are issued one at a time to the L2 cache over a
// request/complete handshake.
//
// Issue FSM states:
//   state  | meaning
//   S_IDLE | no request outstanding; pops the queue head when one is waiting
//   S_REQ  | request held on the L2 port until complete_l2cache_pref
module prefetch_stride_gen #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_OFFSET = 4,
  parameter int QDEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  l1_miss_valid,
  input  logic                  l1_miss_type,
  input  logic [ADDR_WIDTH-1:0] l1_miss_addr,
  output logic                  req_pref_l2cache,
  output logic                  type_pref_l2cache,
  output logic [ADDR_WIDTH-1:0] addr_pref_l2cache,
  input  logic                  complete_l2cache_pref,
  input  logic                  hit_l2cache_pref,
  input  logic                  miss_l2cache_pref,
  output logic [15:0]           pref_issued_cnt,
  output logic [15:0]           pref_redundant_cnt
);

  localparam int LW  = ADDR_WIDTH - LINE_OFFSET;
  localparam int QPW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [QPW:0] QFULL = QDEPTH[QPW:0];

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Stride trackers, index 0 = instruction, 1 = data.
  logic                 trk_valid  [2];
  logic [LW-1:0]        trk_last   [2];
  logic signed [LW-1:0] trk_stride [2];
  logic [1:0]           trk_conf   [2];

  // Candidate FIFO.
  logic                  q_valid [QDEPTH];
  logic                  q_type  [QDEPTH];
  logic [ADDR_WIDTH-1:0] q_addr  [QDEPTH];
  logic [QPW-1:0]        q_head;
  logic [QPW-1:0]        q_tail;
  logic [QPW:0]          q_count;

  logic [LW-1:0]         miss_line;
  logic signed [LW-1:0]  miss_delta;
  logic                  stride_match;
  logic [1:0]            conf_next;
  logic                  cand_gen;
  logic [LW-1:0]         cand_line;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic                  cand_dup;
  logic                  q_full;
  logic                  q_pop;
  logic                  q_push;
  logic                  flush;

  // Byte offset within a line never matters for stride detection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^l1_miss_addr[LINE_OFFSET-1:0];

  assign flush        = miss_l2cache_pref;
  assign miss_line    = l1_miss_addr[ADDR_WIDTH-1:LINE_OFFSET];
  assign miss_delta   = miss_line - trk_last[l1_miss_type];
  assign stride_match = trk_valid[l1_miss_type] && (miss_delta != '0) &&
                        (miss_delta == trk_stride[l1_miss_type]);
  assign conf_next    = (trk_conf[l1_miss_type] == 2'd3) ? 2'd3
                                                         : trk_conf[l1_miss_type] + 2'd1;
  assign cand_gen     = l1_miss_valid && stride_match && (conf_next >= 2'd2);
  // Line arithmetic wraps modulo the line-number width, which is the same as
  // wrapping the byte address modulo 2^ADDR_WIDTH.
  assign cand_line    = miss_line + $unsigned(miss_delta);
  assign cand_addr    = {cand_line, {LINE_OFFSET{1'b0}}};

  assign q_full = (q_count == QFULL);
  // A flush blocks the pop so that no request starts from a discarded entry.
  assign q_pop  = (state_q == S_IDLE) && (q_count != '0) && !flush;
  // A full queue still accepts when its head leaves on the same edge.
  assign q_push = cand_gen && !cand_dup && !flush && (!q_full || q_pop);

  // Drop a candidate already waiting in the queue or currently in flight.
  always_comb begin
    cand_dup = req_pref_l2cache && (type_pref_l2cache == l1_miss_type) &&
               (addr_pref_l2cache == cand_addr);
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_valid[i] && (q_type[i] == l1_miss_type) && (q_addr[i] == cand_addr)) begin
        cand_dup = 1'b1;
      end
    end
  end

  // Stride tracker update for the tracker selected by the miss type.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int t = 0; t < 2; t++) begin
        trk_valid[t]  <= 1'b0;
        trk_last[t]   <= '0;
        trk_stride[t] <= '0;
        trk_conf[t]   <= 2'd0;
      end
    end else if (l1_miss_valid) begin
      if (!trk_valid[l1_miss_type]) begin
        trk_valid[l1_miss_type]  <= 1'b1;
        trk_last[l1_miss_type]   <= miss_line;
        trk_stride[l1_miss_type] <= '0;
        trk_conf[l1_miss_type]   <= 2'd0;
      end else if (miss_delta == '0) begin
        // Repeat miss to the same line: tracker unchanged.
      end else if (stride_match) begin
        trk_conf[l1_miss_type] <= conf_next;
        trk_last[l1_miss_type] <= miss_line;
      end else begin
        trk_stride[l1_miss_type] <= miss_delta;
        trk_conf[l1_miss_type]   <= 2'd0;
        trk_last[l1_miss_type]   <= miss_line;
      end
    end
  end

  // Candidate FIFO: push at tail, pop at head, flush discards everything queued.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_valid[i] <= 1'b0;
        q_type[i]  <= 1'b0;
        q_addr[i]  <= '0;
      end
    end else if (flush) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_valid[i] <= 1'b0;
      end
    end else begin
      // Pop is written before push: when full, head and tail share a slot and
      // the new entry has to win.
      if (q_pop) begin
        q_valid[q_head] <= 1'b0;
        q_head          <= q_head + 1'b1;
      end
      if (q_push) begin
        q_valid[q_tail] <= 1'b1;
        q_type[q_tail]  <= l1_miss_type;
        q_addr[q_tail]  <= cand_addr;
        q_tail          <= q_tail + 1'b1;
      end
      case ({q_push, q_pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM next-state logic; complete/hit only matter in S_REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (q_pop) state_d = S_REQ;
      S_REQ:  if (complete_l2cache_pref) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered L2 request port: loaded from the queue head, cleared on completion.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_pref_l2cache  <= 1'b0;
      type_pref_l2cache <= 1'b0;
      addr_pref_l2cache <= '0;
    end else if (state_q == S_IDLE && q_pop) begin
      req_pref_l2cache  <= 1'b1;
      type_pref_l2cache <= q_type[q_head];
      addr_pref_l2cache <= q_addr[q_head];
    end else if (state_q == S_REQ && complete_l2cache_pref) begin
      req_pref_l2cache  <= 1'b0;
      type_pref_l2cache <= 1'b0;
      addr_pref_l2cache <= '0;
    end
  end

  // Statistics counters, free-running with 16-bit wrap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pref_issued_cnt    <= 16'd0;
      pref_redundant_cnt <= 16'd0;
    end else begin
      if (state_q == S_IDLE && q_pop) begin
        pref_issued_cnt <= pref_issued_cnt + 16'd1;
      end
      if (state_q == S_REQ && complete_l2cache_pref && hit_l2cache_pref) begin
        pref_redundant_cnt <= pref_redundant_cnt + 16'd1;
      end
    end
  end

endmodule
